// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream core and the job arbiter that feeds it.
package rc4_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CORE_RST = 2'd1,
    RUN      = 2'd2,
    RESP     = 2'd3
  } rc4_state_e;

  localparam int RC4_NUM_BYTES      = 4;
  localparam int RC4_TIMEOUT_CYCLES = 2048;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request above last_grant, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_any && req[pos]) begin
        grant_any  = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/rc4_job_arbiter.sv
// Shares one RC4 keystream core among NUM_REQ requesters: accept, reset core, run, respond.
//
//   state    | meaning
//   IDLE     | pick next requester round-robin, latch job, length-check it
//   CORE_RST | hold core_rst_n low for CORE_RST_CYCLES to clear sticky done
//   RUN      | core_start high, watchdog counting down to timeout
//   RESP     | present result to granted requester until it accepts
module rc4_job_arbiter
  import rc4_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int NUMS_OF_BYTES   = RC4_NUM_BYTES,
  parameter int CORE_RST_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = RC4_TIMEOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*NUMS_OF_BYTES*8-1:0] req_key,
  input  logic [NUM_REQ*8-1:0]            req_key_len,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [NUMS_OF_BYTES*8-1:0]      rsp_ckey,
  output logic                            rsp_err,
  output logic                            core_rst_n,
  output logic                            core_start,
  output logic [NUMS_OF_BYTES*8-1:0]      core_key,
  output logic [7:0]                      core_key_length,
  input  logic                            core_done,
  input  logic [NUMS_OF_BYTES*8-1:0]      core_ckey
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int KEY_W   = NUMS_OF_BYTES * 8;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > CORE_RST_CYCLES) ? TIMEOUT_CYCLES : CORE_RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  rc4_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   key_q, ckey_q, masked_ckey, sel_key;
  logic [7:0]         len_q, sel_len;
  logic [IDX_W-1:0]   g_q, last_grant_q, grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic               grant_any, bad_len, err_q;
  logic               accept, reject, run_done, run_timeout, rsp_hs;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant_oh),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  assign sel_key = req_key[grant_idx*KEY_W +: KEY_W];
  assign sel_len = req_key_len[grant_idx*8 +: 8];
  assign bad_len = (sel_len == 8'd0) || (sel_len > 8'(NUMS_OF_BYTES));

  always_comb begin
    masked_ckey = '0;
    for (int i = 0; i < NUMS_OF_BYTES; i++) begin
      if (i < int'(len_q)) masked_ckey[i*8 +: 8] = core_ckey[i*8 +: 8];
    end
  end

  // One down-counter serves as the core-reset timer and then as the RUN watchdog.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready   = '0;
    rsp_valid   = '0;
    accept      = 1'b0;
    reject      = 1'b0;
    run_done    = 1'b0;
    run_timeout = 1'b0;
    rsp_hs      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && grant_any) begin
          req_ready = grant_oh;
          accept    = 1'b1;
          if (bad_len) begin
            reject  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = CORE_RST;
            cnt_d   = CNT_W'(CORE_RST_CYCLES - 1);
          end
        end
      end
      CORE_RST: begin
        if (cnt_q == '0) begin
          state_d = RUN;
          cnt_d   = CNT_W'(TIMEOUT_CYCLES);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RUN: begin
        if (core_done) begin
          run_done = 1'b1;
          state_d  = RESP;
        end else if (cnt_q == '0) begin
          run_timeout = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rst_n) rsp_valid[g_q] = 1'b1;
        if (rsp_ready[g_q]) begin
          rsp_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      key_q        <= '0;
      len_q        <= '0;
      g_q          <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      ckey_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        key_q <= sel_key;
        len_q <= sel_len;
        g_q   <= grant_idx;
      end
      if (reject || run_timeout) begin
        ckey_q <= '0;
        err_q  <= 1'b1;
      end else if (run_done) begin
        ckey_q <= masked_ckey;
        err_q  <= 1'b0;
      end
      if (rsp_hs) last_grant_q <= g_q;
    end
  end

  assign core_rst_n      = rst_n && (state_q != CORE_RST);
  assign core_start      = rst_n && (state_q == RUN);
  assign core_key        = key_q;
  assign core_key_length = len_q;
  assign rsp_ckey        = ckey_q;
  assign rsp_err         = err_q;

endmodule
